i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (slave) that sits directly downstream of the team's I2C master on the shared SCL/SDA bus. It answers a 7-bit device address and exposes a small byte-wide register file using the standard pointer protocol: address+W, register pointer, then data bytes. A read uses address+W, pointer, repeated START, then address+R. The block oversamples SCL/SDA on the bus's 4x phantom clock and drives SDA open-drain style. It is the responder the master is tested against and the model for on-board peripherals.

## Interface
Parameters:
- TARGET_ADDR, 7'h50, device address answered; all other addresses are ignored.
- DEPTH, 16, number of 8-bit registers; power of two, 2..256.

Ports:
- scl_4x  in  1  clock, 4x SCL rate; all logic on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- scl_i  in  1  bus SCL as seen by the target.
- sda_i  in  1  bus SDA as seen by the target.
- sda_o  out  1  SDA drive; 0 pulls low, 1 releases. Reset 1.
- busy  out  1  high from an address-matched START until STOP. Reset 0.
- wr_strobe  out  1  one-cycle pulse per register written. Reset 0.
- wr_index  out  $clog2(DEPTH)  index written, valid with wr_strobe. Reset 0.
- wr_data  out  8  byte written, valid with wr_strobe. Reset 0.

## Operation
- Registers scl_q and sda_q hold the previous-cycle samples.
- Edge and condition detection:
  - scl_rise = scl_i & ~scl_q; scl_fall = ~scl_i & scl_q.
  - START = scl_i & scl_q & sda_q & ~sda_i.
  - STOP = scl_i & scl_q & ~sda_q & sda_i.
- Data is sampled on scl_rise, MSB first. The 3-bit bit counter is cleared by START and at each ACK slot.
- States:
  - IDLE: waits for START, which goes to ADDR.
  - ADDR: shifts 8 bits. If bits[7:1] == TARGET_ADDR, go to ADDR_ACK and raise busy. Otherwise go to IGNORE.
  - ADDR_ACK: sda_o=0 for one SCL period. If R/W=0, go to REG. If R/W=1, go to RDATA and load shift register with reg[ptr].
  - REG: shifts 8 bits. ptr <= byte mod DEPTH. Go to REG_ACK.
  - REG_ACK: sda_o=0 for one SCL period, then WDATA.
  - WDATA: shifts 8 bits. reg[ptr] <= byte and wr_strobe pulses. Go to WDATA_ACK.
  - WDATA_ACK: sda_o=0 for one SCL period, then WDATA. Back-to-back bytes handled per Configuration.
  - RDATA: drives shift MSB on each scl_fall. After 8 bits, release sda_o and go to RDATA_ACK.
  - RDATA_ACK: samples sda_i on scl_rise.
    - 0 (ACK): ptr per Configuration, reload shift register, go to RDATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: sda_o=1 and busy=0; waits for START or STOP.
- All sda_o changes are registered and launched on the cycle after scl_fall is detected. sda_o never changes while SCL is high, except for release at STOP or START.
- START in any state (repeated START):
  - Goes to ADDR and releases sda_o.
  - Keeps ptr and register contents.
  - busy stays as-is until the new address is decoded.
- STOP in any state goes to IDLE with sda_o=1 and busy=0. A partially shifted byte is discarded: no write, no wr_strobe.
- rst clears:
  - all registers, including the register file, to 0;
  - ptr to 0 and state to IDLE.
  - Reset mid-transfer releases SDA immediately on the next edge.
- The general call address (0x00) is not supported and is treated as a mismatch.

## Timing
- With 4x oversampling, SCL high lasts 2 scl_4x cycles and low lasts 2 cycles.
- scl_rise and scl_fall are each detected 1 cycle after the bus edge.
- ACK/data drive appears on sda_o 1 cycle after scl_fall detection. This is within the low phase, before the next rise.
- wr_strobe pulses in the cycle after the 8th data-bit scl_rise. wr_index and wr_data hold until the next strobe.
- Read-data latency: reg[ptr] is captured at the ADDR_ACK→RDATA transition. A write and a read of the same index cannot overlap, because the bus is serial.
- Simultaneous START and scl_fall cannot occur, since START requires SCL high. START takes priority over data sampling in the same cycle.

## Configuration
- I2C_TGT_AUTOINC_EN:
  - Defined: after each written byte and each ACKed read byte, ptr <= (ptr+1) mod DEPTH (wraps at DEPTH-1 → 0). Multi-byte bursts are supported.
  - Undefined: ptr is unchanged; repeated bytes rewrite and re-read the same register.
  - The wr_strobe/wr_index interface is identical in both builds.

## Test plan
- Write: START, 0xA0, 0x92, 0xAC, STOP.
  - ACK low on all three ACK slots.
  - One wr_strobe with wr_index=2 (0x92 mod 16) and wr_data=0xAC.
  - busy falls at STOP.
- Read after write: START, 0xA0, 0x92, repeated START, 0xA1.
  - Target drives 0xAC MSB-first.
  - Master NACK → sda_o=1 and state IGNORE until STOP.
- Address mismatch: START, 0xA2, 0x55, STOP.
  - sda_o stays 1 throughout.
  - No wr_strobe; busy stays 0.
- Burst with I2C_TGT_AUTOINC_EN: write 0xA0, 0x0F, 0x11, 0x22.
  - Strobes at index 15 then 0 (wrap).
  - Without the macro, index 15 twice and reg[15]=0x22.
- Abort: STOP after 5 bits of a data byte.
  - No strobe; register unchanged.
  - Next transaction works normally.
- Reset: assert rst while the target drives an ACK low.
  - sda_o=1, busy=0, and reg[*]=0 on the following cycle.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte-wide register file behind a pointer
// protocol (addr+W, pointer, data... / addr+W, pointer, Sr, addr+R, data...).
// SCL/SDA are oversampled on scl_4x; SDA is driven open-drain style (0 pulls low).
// Optional feature macro: I2C_TGT_AUTOINC_EN - pointer advances after each
// written byte and each ACKed read byte; otherwise it stays put.
// state_dbg exposes the FSM state for observation.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16
) (
    input  logic                     scl_4x,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o,
    output logic                     busy,
    output logic                     wr_strobe,
    output logic [$clog2(DEPTH)-1:0] wr_index,
    output logic [7:0]               wr_data,
    output logic [3:0]               state_dbg
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_REG       = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    state_t        state, state_n;
    logic          scl_q, sda_q;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_adv;
    logic [7:0]    regs [DEPTH];

    logic          scl_rise, scl_fall, start_c, stop_c, last_bit, addr_match;
    logic [7:0]    byte_in;

    assign scl_rise = scl_i & ~scl_q;
    assign scl_fall = ~scl_i & scl_q;
    assign start_c  = scl_i & scl_q & sda_q & ~sda_i;
    assign stop_c   = scl_i & scl_q & ~sda_q & sda_i;

    // Byte as it stands once the current bit is shifted in (MSB first).
    assign byte_in  = {shift[6:0], sda_i};
    assign last_bit = scl_rise && (bit_cnt == 3'd7);
    // General call (0x00) is never answered, even if TARGET_ADDR were 0.
    assign addr_match = (byte_in[7:1] == TARGET_ADDR) && (byte_in[7:1] != 7'h00);

`ifdef I2C_TGT_AUTOINC_EN
    assign ptr_adv = ptr + 1'b1;
`else
    assign ptr_adv = ptr;
`endif

    assign state_dbg = state;

    // wr_strobe is a valid-only pulse with no ready: the consumer must take
    // wr_index/wr_data in the single cycle wr_strobe is high; both then hold.

    // State register.
    always_ff @(posedge scl_4x) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; START/STOP override every state.
    always_comb begin
        state_n = state;
        if (start_c) begin
            state_n = S_ADDR;
        end else if (stop_c) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_ADDR:      if (last_bit) state_n = addr_match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  if (scl_rise) state_n = shift[0] ? S_RDATA : S_REG;
                S_REG:       if (last_bit) state_n = S_REG_ACK;
                S_REG_ACK:   if (scl_rise) state_n = S_WDATA;
                S_WDATA:     if (last_bit) state_n = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_rise) state_n = S_WDATA;
                S_RDATA:     if (last_bit) state_n = S_RDATA_ACK;
                S_RDATA_ACK: if (scl_rise) state_n = sda_i ? S_IGNORE : S_RDATA;
                default:     state_n = state;
            endcase
        end
    end

    // Datapath: sampling, shifting, SDA drive, pointer and register file.
    // SDA only changes on a detected scl_fall (SCL low), or at START/STOP/reset.
    // ACK states hold SDA low from the fall before the ACK clock to the fall
    // after it; the following state's fall action releases or drives data.
    always_ff @(posedge scl_4x) begin
        if (rst) begin
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            sda_o     <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            scl_q     <= scl_i;
            sda_q     <= sda_i;
            wr_strobe <= 1'b0;
            if (start_c) begin
                bit_cnt <= '0;
                sda_o   <= 1'b1;
            end else if (stop_c) begin
                bit_cnt <= '0;
                sda_o   <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                bit_cnt <= '0;
                                busy    <= addr_match;
                            end
                        end
                    end
                    S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                        if (scl_fall) sda_o <= 1'b0;
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            // Read direction: capture the byte to send now.
                            if (state == S_ADDR_ACK && shift[0]) shift <= regs[ptr];
                        end
                    end
                    S_REG, S_WDATA: begin
                        if (scl_fall) sda_o <= 1'b1;
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (state == S_REG) begin
                                    ptr <= byte_in[IW-1:0];
                                end else begin
                                    regs[ptr] <= byte_in;
                                    wr_strobe <= 1'b1;
                                    wr_index  <= ptr;
                                    wr_data   <= byte_in;
                                    ptr       <= ptr_adv;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            sda_o <= shift[7];
                            shift <= {shift[6:0], 1'b0};
                        end
                        if (scl_rise) bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
                    end
                    S_RDATA_ACK: begin
                        if (scl_fall) sda_o <= 1'b1;
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (sda_i) begin
                                busy <= 1'b0;
                            end else begin
                                ptr   <= ptr_adv;
                                shift <= regs[ptr_adv];
                            end
                        end
                    end
                    S_IGNORE: begin
                        sda_o <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-level I2C master drives the bus; expected
// register writes and read bytes are queued and checked by separate monitors.
module tb_i2c_target_regs;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_IGNORE = 4'd9;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_i;
    logic       sda_o, busy, wr_strobe;
    logic [3:0] wr_index;
    logic [7:0] wr_data;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  rd_obs;
    event        rd_ev;

    logic watch = 1'b0;
    logic sda_low_seen = 1'b0;
    logic busy_seen = 1'b0;

    // Wired-AND bus: the target can only pull the master's SDA low.
    assign sda_i = sda_m & sda_o;

    i2c_target_regs #(.TARGET_ADDR(7'h50), .DEPTH(16)) dut (
        .scl_4x    (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_i),
        .sda_o     (sda_o),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor.
    always @(negedge clk) begin
        if (!rst && wr_strobe === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got idx %0d data %0h expected no strobe", wr_index, wr_data);
            end else begin
                chk("wr_strobe", 32'({wr_index, wr_data}), 32'(exp_wr_q.pop_front()));
            end
        end
        if (watch && sda_o !== 1'b1) sda_low_seen = 1'b1;
        if (watch && busy  !== 1'b0) busy_seen = 1'b1;
    end

    // Read-byte monitor.
    initial forever begin
        @(rd_ev);
        if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %0h expected no read", rd_obs);
        end else begin
            chk("rd_data", 32'(rd_obs), 32'(exp_rd_q.pop_front()));
        end
    end

    // Bus driver tasks; every step happens on a falling clock edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        scl_m = 1'b0; sda_m = b; tick(); tick();
        scl_m = 1'b1; tick(); tick();
    endtask

    task automatic recv_bit(output logic b);
        scl_m = 1'b0; sda_m = 1'b1; tick(); tick();
        scl_m = 1'b1; tick(); b = sda_i; tick();
    endtask

    task automatic start_cond();
        scl_m = 1'b0; sda_m = 1'b1; tick(); tick();
        scl_m = 1'b1; tick(); tick();
        sda_m = 1'b0; tick(); tick();
    endtask

    task automatic stop_cond();
        scl_m = 1'b0; sda_m = 1'b0; tick(); tick();
        scl_m = 1'b1; tick(); tick();
        sda_m = 1'b1; tick(); tick();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] d0,
                            input logic [7:0] d1, input int n);
        logic ack;
        start_cond();
        write_byte(8'hA0, ack); chk("addr_ack", 32'(ack), 32'h0);
        chk("busy_after_addr", 32'(busy), 32'h1);
        write_byte(p, ack);     chk("reg_ack", 32'(ack), 32'h0);
        for (int i = 0; i < n; i++) begin
            write_byte((i == 0) ? d0 : d1, ack);
            chk("data_ack", 32'(ack), 32'h0);
        end
        stop_cond();
        chk("busy_after_stop", 32'(busy), 32'h0);
        chk("state_after_stop", 32'(state_dbg), 32'(ST_IDLE));
    endtask

    task automatic do_read(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        start_cond();
        write_byte(8'hA0, ack); chk("rd_addr_w_ack", 32'(ack), 32'h0);
        write_byte(p, ack);     chk("rd_reg_ack", 32'(ack), 32'h0);
        start_cond();
        write_byte(8'hA1, ack); chk("rd_addr_r_ack", 32'(ack), 32'h0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            rd_obs = d;
            -> rd_ev;
        end
        chk("nack_state_ignore", 32'(state_dbg), 32'(ST_IGNORE));
        chk("nack_sda_released", 32'(sda_o), 32'h1);
        chk("nack_busy_low", 32'(busy), 32'h0);
        stop_cond();
        chk("rd_state_after_stop", 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // Directed scenarios.
    initial begin
        logic ack;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) tick();
        chk("rst_sda_o", 32'(sda_o), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_wr_index_data", 32'({wr_index, wr_data}), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (4) tick();

        // Single write: reg[0x92 mod 16 = 2] <= 0xAC.
        exp_wr_q.push_back({4'd2, 8'hAC});
        do_write(8'h92, 8'hAC, 8'h00, 1);

        // Read it back through a repeated START.
        exp_rd_q.push_back(8'hAC);
        do_read(8'h92, 1);

        // Address mismatch (0x51): no ACK, no drive, no busy, no strobe.
        watch = 1'b1;
        start_cond();
        write_byte(8'hA2, ack); chk("mismatch_addr_nack", 32'(ack), 32'h1);
        write_byte(8'h55, ack); chk("mismatch_data_nack", 32'(ack), 32'h1);
        stop_cond();
        watch = 1'b0;
        chk("mismatch_sda_never_low", 32'(sda_low_seen), 32'h0);
        chk("mismatch_busy_never_high", 32'(busy_seen), 32'h0);

        // Burst at index 15.
        exp_wr_q.push_back({4'd15, 8'h11});
`ifdef I2C_TGT_AUTOINC_EN
        exp_wr_q.push_back({4'd0, 8'h22});
        exp_rd_q.push_back(8'h11);
        exp_rd_q.push_back(8'h22);
`else
        exp_wr_q.push_back({4'd15, 8'h22});
        exp_rd_q.push_back(8'h22);
        exp_rd_q.push_back(8'h22);
`endif
        do_write(8'h0F, 8'h11, 8'h22, 2);
        do_read(8'h0F, 2);

        // Abort: STOP after 5 data bits of 0x5A to index 2.
        start_cond();
        write_byte(8'hA0, ack); chk("abort_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h02, ack); chk("abort_reg_ack", 32'(ack), 32'h0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        stop_cond();
        chk("abort_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        chk("abort_busy_low", 32'(busy), 32'h0);
        exp_wr_q.push_back({4'd3, 8'h3C});
        do_write(8'h03, 8'h3C, 8'h00, 1);
        exp_rd_q.push_back(8'hAC);
        do_read(8'h02, 1);

        // Reset while the target holds the address ACK low.
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(8'hA0 >> i);
        scl_m = 1'b0; sda_m = 1'b1; tick(); tick();
        chk("ack_low_before_rst", 32'(sda_o), 32'h0);
        rst = 1'b1;
        tick();
        chk("rst_mid_sda_o", 32'(sda_o), 32'h1);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_mid_wr_regs", 32'({wr_index, wr_data}), 32'h0);
        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) tick();
        exp_rd_q.push_back(8'h00);
        do_read(8'h02, 1);
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h00);
        do_read(8'h0F, 2);

        repeat (4) tick();
        chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
        chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
